// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_pkg;

    typedef logic [31:0] int_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        HOLD    = 2'd2
    } fetch_state_t;

    localparam int_t NOP = 32'h0000_0000;

    // Memory is word addressed; the byte offset is never sent out.
    function automatic int_t align_word(input int_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// PC, memory and decode signals of the fetch stage.
// INSTRUCTION_FETCH_ALIGN_CHECK_EN adds the fetchFault signal.
interface instruction_fetch_if;
    import instruction_fetch_pkg::*;

    int_t pcValue;
    logic pcToggle;
    logic pcStall;
    logic flush;
    logic memReq;
    int_t memAddr;
    logic memAck;
    int_t memData;
    logic instValid;
    int_t instruction;
    int_t instPc;
    logic decodeReady;
`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
    logic fetchFault;

    modport master (
        input  pcValue, pcToggle, flush, memAck, memData, decodeReady,
        output pcStall, memReq, memAddr, instValid, instruction, instPc, fetchFault
    );
    modport slave (
        output pcValue, pcToggle, flush, memAck, memData, decodeReady,
        input  pcStall, memReq, memAddr, instValid, instruction, instPc, fetchFault
    );
`else
    modport master (
        input  pcValue, pcToggle, flush, memAck, memData, decodeReady,
        output pcStall, memReq, memAddr, instValid, instruction, instPc
    );
    modport slave (
        output pcValue, pcToggle, flush, memAck, memData, decodeReady,
        input  pcStall, memReq, memAddr, instValid, instruction, instPc
    );
`endif

endinterface

// File: rtl/instruction_fetch_skid_buffer.sv
// One-entry holding register for a fetched word that decode could not take yet.
module instruction_fetch_skid_buffer
    import instruction_fetch_pkg::*;
#(
    parameter int_t NOP_WORD = NOP
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_drain,
    input  logic i_clear,
    input  int_t i_data,
    input  int_t i_addr,
    input  logic i_fault,
    output int_t o_data,
    output int_t o_addr,
    output logic o_fault
);

    int_t r_data;
    int_t r_addr;
    logic r_fault;

    // Capture on load, empty on drain or clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data  <= NOP_WORD;
            r_addr  <= 32'h0000_0000;
            r_fault <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_addr  <= i_addr;
            r_fault <= i_fault;
        end else if (i_drain || i_clear) begin
            r_data  <= NOP_WORD;
            r_addr  <= 32'h0000_0000;
            r_fault <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_addr  = r_addr;
    assign o_fault = r_fault;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: turns PC toggles into memory reads and hands words to decode.
// INSTRUCTION_FETCH_ALIGN_CHECK_EN reports misaligned PCs instead of zeroing bits.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic RESET_TOGGLE = 1'b1,
    parameter int_t RESET_PC     = 32'h0000_3000,
    parameter int_t NOP_WORD     = NOP
) (
    input  logic                clock,
    input  logic                reset,
    instruction_fetch_if.master bus
);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_REQUEST = REQUEST;
    localparam logic [1:0] S_HOLD    = HOLD;

    logic [1:0] r_state;
    logic       r_last_toggle;
    logic       r_mem_req;
    int_t       r_mem_addr;
    logic       r_discard;
    logic       r_inst_valid;
    int_t       r_instruction;
    int_t       r_inst_pc;
    logic       r_fetch_fault;

    logic [1:0] w_state_nxt;
    logic       w_toggle_nxt;
    logic       w_req_nxt;
    int_t       w_addr_nxt;
    logic       w_discard_nxt;
    logic       w_new_pc;
    logic       w_out_free;
    logic       w_consume;
    logic       w_stall;
    logic       w_load_out;
    int_t       w_out_data;
    int_t       w_out_pc;
    logic       w_out_fault;
    logic       w_skid_load;
    logic       w_skid_drain;
    logic       w_skid_clear;
    int_t       w_skid_in_data;
    int_t       w_skid_in_addr;
    logic       w_skid_in_fault;
    int_t       w_skid_data;
    int_t       w_skid_addr;
    logic       w_skid_fault;
    logic       w_unused;

    assign w_new_pc   = (bus.pcToggle != r_last_toggle);
    assign w_out_free = !r_inst_valid || bus.decodeReady;
    assign w_consume  = r_inst_valid && bus.decodeReady;

    // Next-state and datapath steering for the IDLE/REQUEST/HOLD controller.
    always_comb begin
        w_state_nxt     = r_state;
        w_toggle_nxt    = r_last_toggle;
        w_req_nxt       = r_mem_req;
        w_addr_nxt      = r_mem_addr;
        w_discard_nxt   = r_discard;
        w_load_out      = 1'b0;
        w_out_data      = NOP_WORD;
        w_out_pc        = r_mem_addr;
        w_out_fault     = 1'b0;
        w_skid_load     = 1'b0;
        w_skid_drain    = 1'b0;
        w_skid_clear    = 1'b0;
        w_skid_in_data  = bus.memData;
        w_skid_in_addr  = r_mem_addr;
        w_skid_in_fault = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_new_pc) begin
                    w_toggle_nxt = bus.pcToggle;
`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
                    if (bus.pcValue[1:0] != 2'b00) begin
                        // Misaligned PC: skip memory, present a faulting NOP.
                        w_skid_in_data  = NOP_WORD;
                        w_skid_in_addr  = bus.pcValue;
                        w_skid_in_fault = 1'b1;
                        if (w_out_free) begin
                            w_load_out  = 1'b1;
                            w_out_pc    = bus.pcValue;
                            w_out_fault = 1'b1;
                        end else begin
                            w_skid_load = 1'b1;
                            w_state_nxt = S_HOLD;
                        end
                    end else begin
                        w_addr_nxt  = align_word(bus.pcValue);
                        w_req_nxt   = 1'b1;
                        w_state_nxt = S_REQUEST;
                    end
`else
                    w_addr_nxt  = align_word(bus.pcValue);
                    w_req_nxt   = 1'b1;
                    w_state_nxt = S_REQUEST;
`endif
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_REQUEST: begin
                if (bus.memAck) begin
                    w_req_nxt     = 1'b0;
                    w_discard_nxt = 1'b0;
                    w_state_nxt   = S_IDLE;
                    if (r_discard || bus.flush) begin
                        w_load_out = 1'b0;
                    end else if (w_out_free) begin
                        w_load_out = 1'b1;
                        w_out_data = bus.memData;
                    end else begin
                        w_skid_load = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end else if (bus.flush) begin
                    w_discard_nxt = 1'b1;
                end else begin
                    w_discard_nxt = r_discard;
                end
            end
            S_HOLD: begin
                if (bus.flush) begin
                    w_skid_clear = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else if (bus.decodeReady) begin
                    w_load_out   = 1'b1;
                    w_out_data   = w_skid_data;
                    w_out_pc     = w_skid_addr;
                    w_out_fault  = w_skid_fault;
                    w_skid_drain = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Controller state and memory request registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_last_toggle <= RESET_TOGGLE;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= 32'h0000_0000;
            r_discard     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_last_toggle <= w_toggle_nxt;
            r_mem_req     <= w_req_nxt;
            r_mem_addr    <= w_addr_nxt;
            r_discard     <= w_discard_nxt;
        end
    end

    // Output register toward decode; flush wins over a same-cycle load.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_inst_valid  <= 1'b0;
            r_instruction <= NOP_WORD;
            r_inst_pc     <= 32'h0000_0000;
            r_fetch_fault <= 1'b0;
        end else if (bus.flush) begin
            r_inst_valid  <= 1'b0;
            r_instruction <= NOP_WORD;
            r_fetch_fault <= 1'b0;
        end else if (w_load_out) begin
            r_inst_valid  <= 1'b1;
            r_instruction <= w_out_data;
            r_inst_pc     <= w_out_pc;
            r_fetch_fault <= w_out_fault;
        end else if (w_consume) begin
            r_inst_valid  <= 1'b0;
            r_instruction <= NOP_WORD;
            r_fetch_fault <= 1'b0;
        end
    end

    instruction_fetch_skid_buffer #(
        .NOP_WORD (NOP_WORD)
    ) u_skid (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_load  (w_skid_load),
        .i_drain (w_skid_drain),
        .i_clear (w_skid_clear),
        .i_data  (w_skid_in_data),
        .i_addr  (w_skid_in_addr),
        .i_fault (w_skid_in_fault),
        .o_data  (w_skid_data),
        .o_addr  (w_skid_addr),
        .o_fault (w_skid_fault)
    );

    assign w_stall = ((r_state == S_IDLE) && w_new_pc)
                   || ((r_state == S_REQUEST) && !(bus.memAck && w_out_free))
                   || (r_state == S_HOLD);

    assign bus.pcStall     = w_stall;
    assign bus.memReq      = r_mem_req;
    assign bus.memAddr     = r_mem_addr;
    assign bus.instValid   = r_inst_valid;
    assign bus.instruction = r_instruction;
    assign bus.instPc      = r_inst_pc;
`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
    assign bus.fetchFault  = r_fetch_fault;
    assign w_unused        = ^{RESET_PC};
`else
    assign w_unused        = ^{RESET_PC, bus.pcValue[1:0], r_fetch_fault, w_skid_fault};
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; INSTRUCTION_FETCH_ALIGN_CHECK_EN adds the alignment scenario.
module tb_instruction_fetch;

    logic clock;
    logic reset;
    logic tgl;
    int   vectors;
    int   errors;

    instruction_fetch_if bus();

    instruction_fetch dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_pc(input logic [31:0] pc);
        tgl          = ~tgl;
        bus.pcValue  = pc;
        bus.pcToggle = tgl;
    endtask

    task automatic test_reset();
        #3;
        vectors++; if (bus.memReq !== 1'b0) begin errors++; $display("FAIL rst_memReq got %h want 0", bus.memReq); end
        vectors++; if (bus.memAddr !== 32'h0) begin errors++; $display("FAIL rst_memAddr got %h want 0", bus.memAddr); end
        vectors++; if (bus.instValid !== 1'b0) begin errors++; $display("FAIL rst_instValid got %h want 0", bus.instValid); end
        vectors++; if (bus.instruction !== 32'h0) begin errors++; $display("FAIL rst_instruction got %h want 0", bus.instruction); end
        vectors++; if (bus.instPc !== 32'h0) begin errors++; $display("FAIL rst_instPc got %h want 0", bus.instPc); end
        tick(); tick();
        reset = 1'b1;
        tick();
        vectors++; if (bus.memReq !== 1'b0) begin errors++; $display("FAIL idle_no_fetch got %h want 0", bus.memReq); end
        vectors++; if (bus.pcStall !== 1'b0) begin errors++; $display("FAIL idle_stall got %h want 0", bus.pcStall); end
    endtask

    task automatic test_basic_fetch();
        set_pc(32'h0000_3000);
        #1;
        vectors++; if (bus.pcStall !== 1'b1) begin errors++; $display("FAIL basic_stall_toggle got %h want 1", bus.pcStall); end
        tick();
        vectors++; if (bus.memReq !== 1'b1) begin errors++; $display("FAIL basic_memReq got %h want 1", bus.memReq); end
        vectors++; if (bus.memAddr !== 32'h0000_3000) begin errors++; $display("FAIL basic_memAddr got %h want 3000", bus.memAddr); end
        bus.memAck  = 1'b1;
        bus.memData = 32'h2408_0001;
        #1;
        vectors++; if (bus.pcStall !== 1'b0) begin errors++; $display("FAIL basic_stall_ack got %h want 0", bus.pcStall); end
        tick();
        bus.memAck = 1'b0;
        vectors++; if (bus.instValid !== 1'b1) begin errors++; $display("FAIL basic_valid got %h want 1", bus.instValid); end
        vectors++; if (bus.instruction !== 32'h2408_0001) begin errors++; $display("FAIL basic_instr got %h want 24080001", bus.instruction); end
        vectors++; if (bus.instPc !== 32'h0000_3000) begin errors++; $display("FAIL basic_instPc got %h want 3000", bus.instPc); end
        vectors++; if (bus.memReq !== 1'b0) begin errors++; $display("FAIL basic_req_drop got %h want 0", bus.memReq); end
        tick();
        vectors++; if (bus.instValid !== 1'b0) begin errors++; $display("FAIL basic_consume got %h want 0", bus.instValid); end
        vectors++; if (bus.instruction !== 32'h0) begin errors++; $display("FAIL basic_nop got %h want 0", bus.instruction); end
    endtask

    task automatic test_late_ack();
        set_pc(32'h0000_3004);
        tick();
        vectors++; if (bus.memAddr !== 32'h0000_3004) begin errors++; $display("FAIL late_memAddr got %h want 3004", bus.memAddr); end
        for (int i = 0; i < 3; i++) begin
            vectors++; if (bus.memReq !== 1'b1) begin errors++; $display("FAIL late_req_held[%0d] got %h want 1", i, bus.memReq); end
            vectors++; if (bus.pcStall !== 1'b1) begin errors++; $display("FAIL late_stall[%0d] got %h want 1", i, bus.pcStall); end
            tick();
        end
        bus.memAck  = 1'b1;
        bus.memData = 32'h8c09_0004;
        #1;
        vectors++; if (bus.pcStall !== 1'b0) begin errors++; $display("FAIL late_stall_ack got %h want 0", bus.pcStall); end
        tick();
        bus.memAck = 1'b0;
        vectors++; if (bus.instruction !== 32'h8c09_0004) begin errors++; $display("FAIL late_instr got %h want 8c090004", bus.instruction); end
        vectors++; if (bus.instPc !== 32'h0000_3004) begin errors++; $display("FAIL late_instPc got %h want 3004", bus.instPc); end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.decodeReady = 1'b0;
        set_pc(32'h0000_3008);
        tick();
        bus.memAck  = 1'b1;
        bus.memData = 32'h1111_1111;
        tick();
        bus.memAck = 1'b0;
        vectors++; if (bus.instruction !== 32'h1111_1111) begin errors++; $display("FAIL b2b_first got %h want 11111111", bus.instruction); end
        set_pc(32'h0000_300c);
        #1;
        vectors++; if (bus.pcStall !== 1'b1) begin errors++; $display("FAIL b2b_stall_toggle got %h want 1", bus.pcStall); end
        tick();
        vectors++; if (bus.memAddr !== 32'h0000_300c) begin errors++; $display("FAIL b2b_memAddr got %h want 300c", bus.memAddr); end
        bus.memAck  = 1'b1;
        bus.memData = 32'h2222_2222;
        #1;
        vectors++; if (bus.pcStall !== 1'b1) begin errors++; $display("FAIL b2b_stall_blocked got %h want 1", bus.pcStall); end
        tick();
        bus.memAck = 1'b0;
        #1;
        vectors++; if (bus.memReq !== 1'b0) begin errors++; $display("FAIL b2b_req_drop got %h want 0", bus.memReq); end
        vectors++; if (bus.pcStall !== 1'b1) begin errors++; $display("FAIL b2b_hold_stall got %h want 1", bus.pcStall); end
        vectors++; if (bus.instruction !== 32'h1111_1111) begin errors++; $display("FAIL b2b_first_kept got %h want 11111111", bus.instruction); end
        tick();
        vectors++; if (bus.instruction !== 32'h1111_1111) begin errors++; $display("FAIL b2b_first_kept2 got %h want 11111111", bus.instruction); end
        bus.decodeReady = 1'b1;
        tick();
        vectors++; if (bus.instruction !== 32'h2222_2222) begin errors++; $display("FAIL b2b_second got %h want 22222222", bus.instruction); end
        vectors++; if (bus.instPc !== 32'h0000_300c) begin errors++; $display("FAIL b2b_second_pc got %h want 300c", bus.instPc); end
        vectors++; if (bus.pcStall !== 1'b0) begin errors++; $display("FAIL b2b_stall_release got %h want 0", bus.pcStall); end
        tick();
        vectors++; if (bus.instValid !== 1'b0) begin errors++; $display("FAIL b2b_no_dup got %h want 0", bus.instValid); end
    endtask

    task automatic test_flush();
        set_pc(32'h0000_3010);
        tick();
        bus.flush = 1'b1;
        #1;
        vectors++; if (bus.pcStall !== 1'b1) begin errors++; $display("FAIL flush_stall got %h want 1", bus.pcStall); end
        tick();
        bus.flush = 1'b0;
        vectors++; if (bus.memReq !== 1'b1) begin errors++; $display("FAIL flush_req_held got %h want 1", bus.memReq); end
        bus.memAck  = 1'b1;
        bus.memData = 32'hdead_beef;
        tick();
        bus.memAck = 1'b0;
        vectors++; if (bus.memReq !== 1'b0) begin errors++; $display("FAIL flush_req_drop got %h want 0", bus.memReq); end
        vectors++; if (bus.instValid !== 1'b0) begin errors++; $display("FAIL flush_dropped got %h want 0", bus.instValid); end
        set_pc(32'h0000_3040);
        tick();
        vectors++; if (bus.memAddr !== 32'h0000_3040) begin errors++; $display("FAIL flush_target_addr got %h want 3040", bus.memAddr); end
        bus.memAck  = 1'b1;
        bus.memData = 32'h3333_3333;
        tick();
        bus.memAck = 1'b0;
        vectors++; if (bus.instruction !== 32'h3333_3333) begin errors++; $display("FAIL flush_target_instr got %h want 33333333", bus.instruction); end
        vectors++; if (bus.instPc !== 32'h0000_3040) begin errors++; $display("FAIL flush_target_pc got %h want 3040", bus.instPc); end
        set_pc(32'h0000_3044);
        tick();
        bus.memAck  = 1'b1;
        bus.memData = 32'h4444_4444;
        bus.flush   = 1'b1;
        tick();
        bus.memAck = 1'b0;
        bus.flush  = 1'b0;
        vectors++; if (bus.instValid !== 1'b0) begin errors++; $display("FAIL flush_same_cycle got %h want 0", bus.instValid); end
        vectors++; if (bus.instruction !== 32'h0) begin errors++; $display("FAIL flush_same_cycle_nop got %h want 0", bus.instruction); end
    endtask

`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
    task automatic test_align();
        set_pc(32'h0000_3002);
        #1;
        vectors++; if (bus.pcStall !== 1'b1) begin errors++; $display("FAIL align_stall got %h want 1", bus.pcStall); end
        tick();
        vectors++; if (bus.memReq !== 1'b0) begin errors++; $display("FAIL align_no_req got %h want 0", bus.memReq); end
        vectors++; if (bus.fetchFault !== 1'b1) begin errors++; $display("FAIL align_fault got %h want 1", bus.fetchFault); end
        vectors++; if (bus.instValid !== 1'b1) begin errors++; $display("FAIL align_valid got %h want 1", bus.instValid); end
        vectors++; if (bus.instruction !== 32'h0) begin errors++; $display("FAIL align_instr got %h want 0", bus.instruction); end
        vectors++; if (bus.instPc !== 32'h0000_3002) begin errors++; $display("FAIL align_pc got %h want 3002", bus.instPc); end
        tick();
        vectors++; if (bus.fetchFault !== 1'b0) begin errors++; $display("FAIL align_fault_clear got %h want 0", bus.fetchFault); end
    endtask
`endif

    task automatic test_async_reset();
        set_pc(32'h0000_3050);
        tick();
        vectors++; if (bus.memReq !== 1'b1) begin errors++; $display("FAIL areset_pre_req got %h want 1", bus.memReq); end
        #2;
        reset = 1'b0;
        #1;
        vectors++; if (bus.memReq !== 1'b0) begin errors++; $display("FAIL areset_memReq got %h want 0", bus.memReq); end
        vectors++; if (bus.memAddr !== 32'h0) begin errors++; $display("FAIL areset_memAddr got %h want 0", bus.memAddr); end
        vectors++; if (bus.instPc !== 32'h0) begin errors++; $display("FAIL areset_instPc got %h want 0", bus.instPc); end
        vectors++; if (bus.instValid !== 1'b0) begin errors++; $display("FAIL areset_instValid got %h want 0", bus.instValid); end
        tick();
        reset = 1'b1;
    endtask

    initial begin
        vectors         = 0;
        errors          = 0;
        reset           = 1'b0;
        tgl             = 1'b1;
        bus.pcValue     = 32'h0000_2ffc;
        bus.pcToggle    = 1'b1;
        bus.flush       = 1'b0;
        bus.memAck      = 1'b0;
        bus.memData     = 32'h0000_0000;
        bus.decodeReady = 1'b1;
        test_reset();
        test_basic_fetch();
        test_late_ack();
        test_back_to_back();
        test_flush();
`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
        test_align();
`endif
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Consumer side of the program counter interface.
- Detects each new PC via the PC's change-toggle output, issues a req/ack read to instruction memory, and presents the fetched word to decode with a valid/ready handshake.
- Drives the PC's stall input so that no PC value is skipped while a fetch is outstanding or the output is blocked.
- Sits between the PC and the decode stage.

Parameters:
- RESET_TOGGLE, 1: reset value of the local toggle copy. Equals the PC's reset value of its change-toggle output.
- RESET_PC, 32'h00003000: first valid fetch address. Used in tests only; not used by logic.
- NOP_WORD, 32'h00000000: instruction value driven while not valid and on flush.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- pcValue  input  32  current PC value
- pcToggle  input  1  PC change toggle; flips on every PC update
- pcStall  output  1  combinational; holds the PC
- flush  input  1  branch resolved; discard the in-flight or held instruction
- memReq  output  1  registered read request
- memAddr  output  32  registered word address
- memAck  input  1  read done; may be combinational in the cycle memReq is high
- memData  input  32  read data, valid with memAck
- instValid  output  1  registered; instruction available to decode
- instruction  output  32  registered fetched word
- instPc  output  32  registered PC of the instruction
- decodeReady  input  1  decode accepts on a rising edge when instValid && decodeReady

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, lastToggle=RESET_TOGGLE.
  - memReq=0, memAddr=0, instValid=0, instruction=NOP_WORD, instPc=0, discard=0.
- Definitions:
  - newPc = (pcToggle != lastToggle)
  - outFree = !instValid || decodeReady
- FSM states are IDLE, REQUEST and HOLD.
- IDLE:
  - On newPc: lastToggle<=pcToggle, memAddr<=pcValue, memReq<=1, next state REQUEST.
  - Otherwise stay in IDLE.
- REQUEST:
  - memReq stays 1 until memAck is sampled high. memReq never drops early, flush included.
  - On memAck with outFree and !discard and !flush: instruction<=memData, instPc<=memAddr, instValid<=1, memReq<=0, next state IDLE.
  - On memAck with !outFree: capture memData and memAddr in the skid register, memReq<=0, next state HOLD.
  - On memAck with discard||flush: drop the data, memReq<=0, discard<=0, next state IDLE.
- HOLD:
  - When decodeReady: move the skid contents to the output, instValid<=1, next state IDLE.
  - flush in HOLD: drop the skid contents, next state IDLE.
- Consumption: a decode handshake with no new load gives instValid<=0 and instruction<=NOP_WORD.
- pcStall = (state==IDLE && newPc) || (state==REQUEST && !(memAck && outFree)) || state==HOLD.
- Best-case latency: PC toggles in cycle t → memReq in t+1 → with a combinational ack, instValid in t+2. Throughput is 1 instruction per 2 cycles.
- Flush:
  - Clears the output register at the next edge (instValid=0, NOP_WORD). This overrides a same-cycle load.
  - If flush arrives in REQUEST before memAck, set discard=1.
  - pcStall is unaffected, so the jump producer holds its request until the stall clears.
- After reset the PC presents toggle=1, which equals lastToggle, so no fetch occurs. Its first update to 0x3000 (toggle=0) triggers the first fetch.
- memAddr[1:0] is forced to 0 unless the optional feature is enabled.

Optional Feature:
- INSTRUCTION_FETCH_ALIGN_CHECK_EN
- Defined:
  - Adds output port fetchFault (1 bit, registered).
  - A newPc with pcValue[1:0]!=0 issues no memReq and goes straight to load the output: instruction=NOP_WORD, instPc=pcValue, fetchFault=1, instValid=1. It waits in HOLD if !outFree.
  - fetchFault clears whenever the output is consumed or flushed.
- Undefined: no fetchFault port; the low address bits are silently zeroed.

Decomposition:
- Definitions package: int_t, fetch_state_t enum {IDLE, REQUEST, HOLD}, NOP constant.
- One natural sub-module: fetch_skid_buffer, a 1-entry data/addr/fault register with load, drain and clear.

Test Plan:
- Release reset; PC goes 0x2ffc(tgl 1)→0x3000(tgl 0); memory acks combinationally with 0x24080001 → memReq=1/memAddr=0x3000 one cycle after the toggle; instValid=1, instruction=0x24080001, instPc=0x3000 the next cycle; pcStall low in the ack cycle.
- Memory acks 3 cycles late → memReq held high for all 3 cycles, pcStall high throughout, PC value unchanged.
- decodeReady=0 when the ack arrives → state HOLD, pcStall=1; decodeReady=1 → the second instruction appears after the first, nothing lost or duplicated.
- flush asserted in REQUEST before ack → memReq still held until ack; data dropped; instValid=0; the next toggle (jump target 0x3040) fetches 0x3040.
- reset pulled low mid-REQUEST → all outputs return to reset values immediately (async), with no clock edge needed.
- With ALIGN_CHECK_EN, PC=0x3002 → no memReq, fetchFault=1, instruction=0, instPc=0x3002.
